perf_store_monitor: RTL and testbench

- Synthesizable, parametrised successor to the bench-only pass/fail store check and cycle/retire counters around riscvpipeline.
- Sits beside the pipeline core and snoops the memory-stage store port, the writeback retire strobe and an N-channel hazard-event vector.
- Keeps saturating performance counters and a pass/fail/timeout verdict FSM.
- Results freeze once a verdict is reached, so software, a bench or an FPGA debug core can read them at any later time.

---
 rtl/perf_store_monitor.sv | 172 +++++++++++++++++
 tb/tb_perf_store_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_store_monitor.sv
// perf_store_monitor: snoops the pipeline store port, retire strobe and
// hazard-event strobes. Keeps saturating counters and a pass/fail/timeout
// verdict that freezes all results once reached, until reset or clear.
module perf_store_monitor #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned N_EVT       = 4,
    parameter logic [31:0] PASS_ADDR   = 32'd100,
    parameter logic [31:0] PASS_DATA   = 32'd25,
    parameter logic [31:0] IGNORE_ADDR = 32'd96,
    parameter int unsigned TIMEOUT_CYC = 41
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   MemWriteM,
    input  logic [31:0]            DataAdrM,
    input  logic [31:0]            WriteDataM,
    input  logic                   retire_valid,
    input  logic [N_EVT-1:0]       evt,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [CNT_W-1:0]       instr_retired,
    output logic [N_EVT*CNT_W-1:0] evt_count,
    output logic [1:0]             state,
    output logic                   done,
    output logic [31:0]            fail_addr,
    output logic [31:0]            fail_data
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } verdict_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    verdict_e         state_q, state_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] evt_cnt_q [N_EVT];
    logic [CNT_W-1:0] evt_cnt_d [N_EVT];
    logic [31:0]      fail_addr_q, fail_addr_d;
    logic [31:0]      fail_data_q, fail_data_d;

    logic is_pass_store;
    logic is_fail_store;
    logic timeout_hit;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Classify this cycle's store and detect the cycle budget being reached.
    // An unknown MemWriteM falls to the else path and so acts as 0.
    always_comb begin
        is_pass_store = 1'b0;
        is_fail_store = 1'b0;
        timeout_hit   = 1'b0;
        if (MemWriteM) begin
            if (DataAdrM == PASS_ADDR && WriteDataM == PASS_DATA) begin
                is_pass_store = 1'b1;
            end else if (DataAdrM != IGNORE_ADDR) begin
                is_fail_store = 1'b1;
            end
        end
        // A pinned (saturated) count never "reaches" a budget beyond its range.
        if (TIMEOUT_CYC != 0 && cycle_q != CNT_MAX) begin
            if ((64'(cycle_q) + 64'd1) == 64'(TIMEOUT_CYC)) begin
                timeout_hit = 1'b1;
            end
        end
    end

    // Next-state and counter update: clear beats everything, counting and
    // verdicts only happen in RUN, terminal states hold all results.
    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        retired_d   = retired_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        for (int i = 0; i < N_EVT; i++) begin
            evt_cnt_d[i] = evt_cnt_q[i];
        end

        if (clear) begin
            state_d     = ST_RUN;
            cycle_d     = '0;
            retired_d   = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
            for (int i = 0; i < N_EVT; i++) begin
                evt_cnt_d[i] = '0;
            end
        end else if (state_q == ST_RUN) begin
            cycle_d = sat_inc(cycle_q);
            if (retire_valid) begin
                retired_d = sat_inc(retired_q);
            end
            for (int i = 0; i < N_EVT; i++) begin
                if (evt[i]) begin
                    evt_cnt_d[i] = sat_inc(evt_cnt_q[i]);
                end
            end
            if (is_pass_store) begin
                state_d = ST_PASS;
            end else if (is_fail_store) begin
                state_d     = ST_FAIL;
                fail_addr_d = DataAdrM;
                fail_data_d = WriteDataM;
            end else if (timeout_hit) begin
                state_d = ST_TIMEOUT;
            end
        end

        done_d = (state_d != ST_RUN);
    end

    // Verdict register; done is kept as its own flop so every output is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Counter and first-failure capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q     <= '0;
            retired_q   <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            for (int i = 0; i < N_EVT; i++) begin
                evt_cnt_q[i] <= '0;
            end
        end else begin
            cycle_q     <= cycle_d;
            retired_q   <= retired_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            for (int i = 0; i < N_EVT; i++) begin
                evt_cnt_q[i] <= evt_cnt_d[i];
            end
        end
    end

    assign cycle_count   = cycle_q;
    assign instr_retired = retired_q;
    assign state         = state_q;
    assign done          = done_q;
    assign fail_addr     = fail_addr_q;
    assign fail_data     = fail_data_q;

    genvar g;
    generate
        for (g = 0; g < N_EVT; g++) begin : g_pack
            assign evt_count[g*CNT_W +: CNT_W] = evt_cnt_q[g];
        end
    endgenerate

    // An undriven store strobe while the verdict is still open is a wiring bug.
    mem_write_known : assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_RUN && !clear) |-> !$isunknown(MemWriteM));

endmodule

// File: tb/tb_perf_store_monitor.sv
// Testbench for perf_store_monitor: directed table, hand sequences for
// saturation/packing and async reset, and randomized traffic vs a model.
module tb_perf_store_monitor;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    logic        retire_valid;
    logic [3:0]  evt;
    logic [31:0] cycle_count;
    logic [31:0] instr_retired;
    logic [127:0] evt_count;
    logic [1:0]  state;
    logic        done;
    logic [31:0] fail_addr;
    logic [31:0] fail_data;

    // Small instance: 4-bit counters, 2 channels, no timeout.
    logic        clear2;
    logic [1:0]  evt2;
    logic [3:0]  cycle_count2;
    logic [3:0]  instr_retired2;
    logic [7:0]  evt_count2;
    logic [1:0]  state2;
    logic        done2;
    logic [31:0] fail_addr2;
    logic [31:0] fail_data2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int unsigned m_state;
    longint      m_cycle;
    longint      m_retired;
    longint      m_evt [4];
    logic [31:0] m_fail_addr;
    logic [31:0] m_fail_data;

    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

    perf_store_monitor dut (
        .clk(clk), .reset(reset), .clear(clear),
        .MemWriteM(mem_write), .DataAdrM(data_adr), .WriteDataM(write_data),
        .retire_valid(retire_valid), .evt(evt),
        .cycle_count(cycle_count), .instr_retired(instr_retired),
        .evt_count(evt_count), .state(state), .done(done),
        .fail_addr(fail_addr), .fail_data(fail_data)
    );

    perf_store_monitor #(.CNT_W(4), .N_EVT(2), .TIMEOUT_CYC(0)) dut2 (
        .clk(clk), .reset(reset), .clear(clear2),
        .MemWriteM(1'b0), .DataAdrM(32'd0), .WriteDataM(32'd0),
        .retire_valid(1'b0), .evt(evt2),
        .cycle_count(cycle_count2), .instr_retired(instr_retired2),
        .evt_count(evt_count2), .state(state2), .done(done2),
        .fail_addr(fail_addr2), .fail_data(fail_data2)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_state = 0;
        m_cycle = 0;
        m_retired = 0;
        for (int i = 0; i < 4; i++) m_evt[i] = 0;
        m_fail_addr = 0;
        m_fail_data = 0;
    endtask

    // One clock edge of the specified behaviour, in plain arithmetic.
    task automatic modelStep(input bit clr, input bit mw, input logic [31:0] adr,
                             input logic [31:0] dat, input bit rv, input logic [3:0] ev);
        if (clr) begin
            modelReset();
        end else if (m_state == 0) begin
            longint next_cycle;
            next_cycle = (m_cycle < MAX32) ? m_cycle + 1 : m_cycle;
            if (mw && adr == 32'd100 && dat == 32'd25) begin
                m_state = 1;
            end else if (mw && adr != 32'd96) begin
                m_state = 2;
                m_fail_addr = adr;
                m_fail_data = dat;
            end else if (m_cycle + 1 == 41) begin
                m_state = 3;
            end
            m_cycle = next_cycle;
            if (rv && m_retired < MAX32) m_retired++;
            for (int i = 0; i < 4; i++)
                if (ev[i] && m_evt[i] < MAX32) m_evt[i]++;
        end
    endtask

    // Drive one cycle of inputs, advance the model, and wait past the edge.
    task automatic applyStimulus(input bit clr, input bit mw, input logic [31:0] adr,
                                 input logic [31:0] dat, input bit rv, input logic [3:0] ev);
        clear = clr;
        mem_write = mw;
        data_adr = adr;
        write_data = dat;
        retire_valid = rv;
        evt = ev;
        modelStep(clr, mw, adr, dat, rv, ev);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".state"}, longint'(state), longint'(m_state));
        checkVal({tag, ".done"}, longint'(done), longint'(m_state != 0));
        checkVal({tag, ".cycle_count"}, longint'(cycle_count), m_cycle);
        checkVal({tag, ".instr_retired"}, longint'(instr_retired), m_retired);
        for (int i = 0; i < 4; i++)
            checkVal($sformatf("%s.evt_count[%0d]", tag, i),
                     longint'(evt_count[i*32 +: 32]), m_evt[i]);
        checkVal({tag, ".fail_addr"}, longint'(fail_addr), longint'(m_fail_addr));
        checkVal({tag, ".fail_data"}, longint'(fail_data), longint'(m_fail_data));
    endtask

    typedef struct {
        int          rep;
        bit          clr;
        bit          mw;
        logic [31:0] adr;
        logic [31:0] dat;
        bit          rv;
        int          ex_state;
        longint      ex_cycle;
        longint      ex_retired;
        logic [31:0] ex_fa;
        logic [31:0] ex_fd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset = 1'b1;
        clear = 1'b0; mem_write = 1'b0; data_adr = '0; write_data = '0;
        retire_valid = 1'b0; evt = '0; clear2 = 1'b0; evt2 = '0;
        modelReset();

        // rep, clr, mw, adr, dat, rv -> state, cycle, retired, fail_addr, fail_data
        vecs.push_back('{4,  0, 0, 0,   0,  1, 0, 4,  4,  0,   0 });
        vecs.push_back('{1,  0, 1, 100, 24, 1, 2, 5,  5,  100, 24});
        vecs.push_back('{3,  0, 1, 100, 25, 1, 2, 5,  5,  100, 24});
        vecs.push_back('{1,  1, 0, 0,   0,  1, 0, 0,  0,  0,   0 });
        vecs.push_back('{1,  0, 0, 0,   0,  0, 0, 1,  0,  0,   0 });
        vecs.push_back('{1,  0, 1, 96,  7,  1, 0, 2,  1,  0,   0 });
        vecs.push_back('{8,  0, 0, 0,   0,  1, 0, 10, 9,  0,   0 });
        vecs.push_back('{1,  0, 1, 100, 25, 1, 1, 11, 10, 0,   0 });
        vecs.push_back('{20, 0, 1, 44,  3,  1, 1, 11, 10, 0,   0 });
        vecs.push_back('{1,  1, 1, 100, 25, 1, 0, 0,  0,  0,   0 });
        vecs.push_back('{40, 0, 0, 0,   0,  0, 0, 40, 0,  0,   0 });
        vecs.push_back('{1,  0, 0, 0,   0,  0, 3, 41, 0,  0,   0 });
        vecs.push_back('{5,  0, 1, 60,  9,  1, 3, 41, 0,  0,   0 });
        vecs.push_back('{1,  1, 0, 0,   0,  0, 0, 0,  0,  0,   0 });
        vecs.push_back('{40, 0, 0, 0,   0,  0, 0, 40, 0,  0,   0 });
        vecs.push_back('{1,  0, 1, 100, 25, 0, 1, 41, 0,  0,   0 });
        vecs.push_back('{1,  1, 0, 0,   0,  0, 0, 0,  0,  0,   0 });
        vecs.push_back('{40, 0, 0, 0,   0,  0, 0, 40, 0,  0,   0 });
        vecs.push_back('{1,  0, 1, 50,  1,  0, 2, 41, 0,  50,  1 });
        vecs.push_back('{1,  1, 0, 0,   0,  0, 0, 0,  0,  0,   0 });
        vecs.push_back('{1,  0, 0, 0,   0,  1, 0, 1,  1,  0,   0 });

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        checkVal("reset.dut2_cycle", longint'(cycle_count2), 0);
        reset = 1'b0;

        // Directed table.
        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].rep; r++)
                applyStimulus(vecs[k].clr, vecs[k].mw, vecs[k].adr, vecs[k].dat, vecs[k].rv, 4'b0);
            checkVal($sformatf("vec%0d.state", k), longint'(state), longint'(vecs[k].ex_state));
            checkVal($sformatf("vec%0d.done", k), longint'(done), longint'(vecs[k].ex_state != 0));
            checkVal($sformatf("vec%0d.cycle", k), longint'(cycle_count), vecs[k].ex_cycle);
            checkVal($sformatf("vec%0d.retired", k), longint'(instr_retired), vecs[k].ex_retired);
            checkVal($sformatf("vec%0d.fail_addr", k), longint'(fail_addr), longint'(vecs[k].ex_fa));
            checkVal($sformatf("vec%0d.fail_data", k), longint'(fail_data), longint'(vecs[k].ex_fd));
        end

        // Saturation and channel packing on the small instance.
        clear2 = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 4'b0);
        clear2 = 1'b0;
        evt2 = 2'b10;
        repeat (10) applyStimulus(0, 0, 0, 0, 0, 4'b0);
        checkVal("sat.mid_ch1", longint'(evt_count2[7:4]), 10);
        checkVal("sat.mid_ch0", longint'(evt_count2[3:0]), 0);
        repeat (10) applyStimulus(0, 0, 0, 0, 0, 4'b0);
        checkVal("sat.ch1", longint'(evt_count2[7:4]), 15);
        checkVal("sat.ch0", longint'(evt_count2[3:0]), 0);
        checkVal("sat.cycle", longint'(cycle_count2), 15);
        checkVal("sat.state", longint'(state2), 0);
        checkVal("sat.done", longint'(done2), 0);
        evt2 = 2'b00;

        // Async reset between edges while holding a FAIL verdict.
        applyStimulus(1, 0, 0, 0, 0, 4'b0);
        repeat (6) applyStimulus(0, 0, 0, 0, 1, 4'b0011);
        applyStimulus(0, 1, 60, 9, 1, 4'b0);
        checkOutput("pre_reset");
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset");
        checkVal("async_reset.dut2_ch1", longint'(evt_count2[7:4]), 0);
        #2;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 4'b0);
        checkOutput("post_reset");
        checkVal("post_reset.cycle", longint'(cycle_count), 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            bit          clr, mw, rv;
            logic [31:0] adr, dat;
            logic [3:0]  ev;
            int          sel;
            clr = ($urandom_range(0, 49) == 0);
            mw  = ($urandom_range(0, 15) == 0);
            sel = $urandom_range(0, 2);
            adr = (sel == 0) ? 32'd96 : (sel == 1) ? 32'd100 : 32'($urandom_range(0, 255));
            dat = ($urandom_range(0, 1) == 1) ? 32'd25 : 32'($urandom_range(0, 40));
            rv  = 1'($urandom_range(0, 1));
            ev  = 4'($urandom);
            applyStimulus(clr, mw, adr, dat, rv, ev);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
